button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Sequences the sampling of already-synchronized, bouncy inputs, such as push-buttons and switches after the 2-FF synchronizer.
- Produces a clean debounced level and a one-cycle rising-edge pulse per bit.
- A shared sample-interval counter acts as the scheduler for all bits. Each bit has its own saturating counter that qualifies stability.
- Sits in io_circuits between the synchronizer and user logic, for example the button/LED/UART control path.

Parameters:
- WIDTH, 1, number of independent input bits.
- SAMPLE_CNT_MAX, 25000, sample interval in clk cycles; must be >= 2.
- PULSE_CNT_MAX, 150, consecutive high samples required to declare a bit pressed; must be >= 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- sync_signal  input  WIDTH  synchronized (not debounced) inputs.
- debounced_signal  output  WIDTH  stable level per bit.
- rising_pulse  output  WIDTH  one-cycle pulse on each 0->1 transition of debounced_signal.
- sample_tick  output  1  sample strobe, exposed for observability.

Behaviour:
- Clocking and reset: one clock. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: sample counter = 0, every per-bit counter = 0, previous-level register = 0.
  - All outputs (debounced_signal, rising_pulse, sample_tick) read 0 in the cycle after rst is sampled high.
- Sample counter:
  - Width is $clog2(SAMPLE_CNT_MAX).
  - Counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick = (counter == SAMPLE_CNT_MAX-1), a combinational decode of the register.
  - The first tick occurs at cycle SAMPLE_CNT_MAX-1, where cycle 0 is the first cycle with rst low. Thereafter a tick occurs every SAMPLE_CNT_MAX cycles.
- Per-bit saturating counter sat[i]:
  - Width is $clog2(PULSE_CNT_MAX+1); range 0..PULSE_CNT_MAX.
  - On a tick with sync_signal[i]=1: sat[i] <= min(sat[i]+1, PULSE_CNT_MAX). It never wraps.
  - On a tick with sync_signal[i]=0: sat[i] <= 0.
  - On a non-tick cycle: sat[i] holds. Input changes between ticks are ignored.
- Debounced level:
  - debounced_signal[i] = (sat[i] == PULSE_CNT_MAX), decoded from the register.
  - It rises in the cycle after the tick that saturates sat[i].
  - It falls in the cycle after the first tick that samples 0.
- Rising-edge pulse:
  - prev[i] <= debounced_signal[i] every cycle.
  - rising_pulse[i] = debounced_signal[i] & ~prev[i].
  - The pulse is high for exactly one cycle, coincident with the first cycle of debounced high.
  - There is no pulse on a falling transition and no repeat pulse while the bit stays saturated.
- Latency: for an input stable high from before tick k, debounced/rising assert 1 cycle after tick k+PULSE_CNT_MAX-1.
- Independence: bits share the tick but are otherwise independent. Simultaneous transitions on several bits produce simultaneous pulses.
- Glitch rejection: any 0 sample before saturation clears sat[i], so no output activity occurs.
- Reset mid-operation:
  - Counters clear, and debounced/pulse drop the next cycle.
  - An input held high through reset must re-qualify through PULSE_CNT_MAX fresh ticks.
  - No rising_pulse is generated merely by leaving reset.
- Tick coinciding with rst: rst wins; no counter updates.

Test Plan:
All scenarios use WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
- Reset/tick timing: rst=1 for 2 cycles, then 0, inputs 0 -> all outputs 0; sample_tick high at cycles 3, 7, 11, 15 only.
- Steady press: sync_signal[0]=1 from cycle 0 -> ticks at 3/7/11 give sat 1/2/3; debounced_signal[0] rises at cycle 12 and stays; rising_pulse[0]=1 only at cycle 12; bit 1 stays 0.
- Bounce rejection: bit0 high for ticks at 3 and 7, low at tick 11, then high at ticks 15/19/23 -> no output until debounced[0] and pulse at cycle 24.
- Hold and release: bit0 high for 10 ticks then low before the next tick -> one pulse only; debounced[0] falls the cycle after the low-sampling tick; no pulse on the fall.
- Independent bits: bit0 high from cycle 0, bit1 high from cycle 8 -> pulse on bit0 at cycle 12, pulse on bit1 at cycle 20; both debounced levels end high.
- Mid-operation reset: with debounced[0]=1 and the input still high, assert rst for 1 cycle at cycle 30 -> outputs 0 from cycle 31; next tick at cycle 34; re-assert and pulse at cycle 43, once.

Source files
------------

// File: rtl/button_debouncer.sv
// Debouncer for already-synchronized inputs: a shared sample tick schedules
// per-bit saturating stability counters, giving a clean level plus rising pulse.
module button_debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rising_pulse,
    output logic             sample_tick
);

    localparam int CW = $clog2(SAMPLE_CNT_MAX);
    localparam int SW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [CW-1:0] TICK_AT = CW'(SAMPLE_CNT_MAX - 1);
    localparam logic [SW-1:0] SAT_MAX = SW'(PULSE_CNT_MAX);

    logic [CW-1:0]    sample_cnt;
    logic [SW-1:0]    sat [WIDTH];
    logic [WIDTH-1:0] prev;

    always_comb begin
        sample_tick = (sample_cnt == TICK_AT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (sample_tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + CW'(1);
        end
    end

    // Counters only move on a tick; any zero sample restarts qualification.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (rst) begin
                sat[i] <= '0;
            end else if (sample_tick) begin
                if (!sync_signal[i]) begin
                    sat[i] <= '0;
                end else if (sat[i] != SAT_MAX) begin
                    sat[i] <= sat[i] + SW'(1);
                end
            end
        end
    end

    always_comb begin
        debounced_signal = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            debounced_signal[i] = (sat[i] == SAT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= debounced_signal;
        end
    end

    always_comb begin
        rising_pulse = debounced_signal & ~prev;
    end

endmodule
